// File: rtl/mig_tt_eval.sv
// Programmable MIG (MAJ3 netlist) evaluator: computes a selected node's full truth table bit-parallel.
// Optional MIG_ERR_CHECK_EN: flag forward/out-of-range references (read as zero) on a sticky err output.
module mig_tt_eval #(
   parameter  int unsigned N_IN      = 7,
   parameter  int unsigned MAX_NODES = 16,
   localparam int unsigned SEL_W     = $clog2(1 + N_IN + MAX_NODES),
   localparam int unsigned TT_W      = 2 ** N_IN,
   localparam int unsigned AW        = $clog2(MAX_NODES),
   localparam int unsigned NUM_W     = $clog2(MAX_NODES + 1),
   localparam int unsigned DW        = 3 * (SEL_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [DW-1:0]    cfg_data,
   input  logic [NUM_W-1:0] num_nodes,
   input  logic [SEL_W-1:0] out_sel,
   input  logic             out_inv,
   input  logic             start,
   output logic             busy,
   output logic             tt_valid,
   input  logic             tt_ready,
   output logic [TT_W-1:0]  tt_data,
   output logic             err
);

`ifdef MIG_ERR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]       r_state, w_state_nxt;
   logic [NUM_W-1:0] r_num, w_num_sat;
   logic [SEL_W-1:0] r_sel;
   logic             r_inv;
   logic [AW-1:0]    r_cnt;
   logic             r_valid, r_busy, r_err;
   logic [TT_W-1:0]  r_data;
   logic [DW-1:0]    r_desc [MAX_NODES];
   logic [TT_W-1:0]  r_node [MAX_NODES];

   logic [DW-1:0]    w_desc;
   logic [TT_W-1:0]  w_a, w_b, w_c, w_maj, w_out_word;
   logic             w_a_err, w_b_err, w_c_err, w_op_err, w_out_err;

   // Projection word of input x_i: bit m equals bit i of m.
   function automatic logic [TT_W-1:0] proj(input int unsigned i);
      logic [TT_W-1:0] w;
      for (int m = 0; m < int'(TT_W); m++) w[m] = ((m >> i) & 1) != 0;
      return w;
   endfunction

   // Signal word lookup; lim = number of nodes legally visible. Returns {err, word}.
   function automatic logic [TT_W:0] sig_word(input logic [SEL_W-1:0] idx,
                                              input logic [NUM_W-1:0] lim);
      int unsigned     ii;
      int unsigned     j;
      logic [TT_W-1:0] w;
      logic            e;
      ii = 32'(idx);
      w  = '0;
      e  = 1'b0;
      if (ii >= 1 && ii <= N_IN) begin
         w = proj(ii - 1);
      end else if (ii > N_IN) begin
         j = ii - N_IN - 1;
         if (j >= MAX_NODES)            e = CHK;
         else if (CHK && j >= 32'(lim)) e = 1'b1;
         else                           w = r_node[AW'(j)];
      end
      return {e, w};
   endfunction

   assign w_num_sat = (num_nodes > NUM_W'(MAX_NODES)) ? NUM_W'(MAX_NODES) : num_nodes;

   // Operand fetch and majority for node r_cnt, plus result-word fetch.
   always_comb begin
      w_desc = r_desc[r_cnt];
      {w_a_err, w_a} = sig_word(w_desc[DW-2 -: SEL_W], NUM_W'(r_cnt));
      {w_b_err, w_b} = sig_word(w_desc[2*SEL_W : SEL_W+1], NUM_W'(r_cnt));
      {w_c_err, w_c} = sig_word(w_desc[SEL_W-1:0], NUM_W'(r_cnt));
      w_a   = w_a ^ {TT_W{w_desc[DW-1]}};
      w_b   = w_b ^ {TT_W{w_desc[2*SEL_W+1]}};
      w_c   = w_c ^ {TT_W{w_desc[SEL_W]}};
      w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
      w_op_err = w_a_err | w_b_err | w_c_err;
      {w_out_err, w_out_word} = sig_word(r_sel, r_num);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = (w_num_sat == '0) ? S_OUT : S_EVAL;
         S_EVAL: if (NUM_W'(r_cnt) == r_num - NUM_W'(1)) w_state_nxt = S_OUT;
         S_OUT:  if (r_valid && tt_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num   <= '0;
         r_sel   <= '0;
         r_inv   <= 1'b0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         for (int i = 0; i < int'(MAX_NODES); i++) begin
            r_desc[i] <= '0;
            r_node[i] <= '0;
         end
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         if (r_state == S_IDLE && cfg_we) r_desc[cfg_addr] <= cfg_data;
         case (r_state)
            S_IDLE: if (start) begin
               r_num <= w_num_sat;
               r_sel <= out_sel;
               r_inv <= out_inv;
               r_cnt <= '0;
               r_err <= 1'b0;
            end
            S_EVAL: begin
               r_node[r_cnt] <= w_maj;
               r_cnt         <= r_cnt + AW'(1);
               if (w_op_err) r_err <= 1'b1;
            end
            S_OUT: begin
               // First OUT cycle captures the result; it then holds until accepted.
               if (!r_valid) begin
                  r_valid <= 1'b1;
                  r_data  <= w_out_word ^ {TT_W{r_inv}};
                  if (w_out_err) r_err <= 1'b1;
               end else if (tt_ready) begin
                  r_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = r_busy;
   assign tt_valid = r_valid;
   assign tt_data  = r_data;
   assign err      = CHK ? r_err : 1'b0;

endmodule

// File: tb/tb_mig_tt_eval.sv
// Self-checking bench for mig_tt_eval: directed and random runs against a per-minterm reference model.
module tb_mig_tt_eval;
   localparam int unsigned N_IN = 7, MAX_NODES = 16, SEL_W = 5, TT_W = 128;
   localparam int unsigned AW = 4, NUM_W = 5, DW = 18;
`ifdef MIG_ERR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk, rst_n, cfg_we, out_inv, start, tt_ready;
   logic [AW-1:0]    cfg_addr;
   logic [DW-1:0]    cfg_data;
   logic [NUM_W-1:0] num_nodes;
   logic [SEL_W-1:0] out_sel;
   logic             busy, tt_valid, err;
   logic [TT_W-1:0]  tt_data;

   mig_tt_eval dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .num_nodes(num_nodes), .out_sel(out_sel), .out_inv(out_inv), .start(start),
      .busy(busy), .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]   m_desc [MAX_NODES];
   logic [TT_W-1:0] m_node [MAX_NODES];
   bit              m_e;

   task automatic check(input string tag, input logic [TT_W-1:0] obs, input logic [TT_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] desc(bit ca, int a, bit cb, int b, bit cc, int c);
      return {ca, SEL_W'(a), cb, SEL_W'(b), cc, SEL_W'(c)};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < int'(MAX_NODES); i++) begin
         m_desc[i] = '0;
         m_node[i] = '0;
      end
   endfunction

   // Value of signal idx at minterm m, with lim nodes legally visible.
   function automatic bit m_sig(int idx, int m, int lim);
      int j;
      if (idx == 0) return 1'b0;
      if (idx <= int'(N_IN)) return ((m >> (idx - 1)) & 1) != 0;
      j = idx - int'(N_IN) - 1;
      if (j >= int'(MAX_NODES)) begin
         if (CHK) m_e = 1'b1;
         return 1'b0;
      end
      if (CHK && j >= lim) begin
         m_e = 1'b1;
         return 1'b0;
      end
      return m_node[j][m];
   endfunction

   task automatic model_run(input int num, input int sel, input bit inv,
                            output logic [TT_W-1:0] ew, output bit ee);
      int n;
      int votes;
      logic [DW-1:0]   d;
      logic [TT_W-1:0] nv;
      n   = (num > int'(MAX_NODES)) ? int'(MAX_NODES) : num;
      m_e = 1'b0;
      for (int k = 0; k < n; k++) begin
         d = m_desc[k];
         for (int m = 0; m < int'(TT_W); m++) begin
            votes = int'(m_sig(int'(d[16:12]), m, k) ^ d[17])
                  + int'(m_sig(int'(d[10:6]), m, k) ^ d[11])
                  + int'(m_sig(int'(d[4:0]), m, k) ^ d[5]);
            nv[m] = votes >= 2;
         end
         m_node[k] = nv;
      end
      for (int m = 0; m < int'(TT_W); m++) ew[m] = m_sig(sel, m, n) ^ inv;
      ee = m_e;
   endtask

   task automatic wr(input int addr, input logic [DW-1:0] data);
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
      tick();
      cfg_we = 1'b0;
      m_desc[addr] = data;
   endtask

   // One run: optional same-cycle descriptor write, optional disturbance while busy.
   task automatic run(input string tag, input int num, input int sel, input bit inv,
                      input int hold, input bit disturb, input bit same_wr, input int waddr,
                      input logic [DW-1:0] wdata, input bit has_c, input logic [TT_W-1:0] exp_c);
      logic [TT_W-1:0] ew;
      bit              ee;
      int              lat;
      int              n;
      if (same_wr) begin
         cfg_we = 1'b1; cfg_addr = AW'(waddr); cfg_data = wdata;
         m_desc[waddr] = wdata;
      end
      model_run(num, sel, inv, ew, ee);
      n = (num > int'(MAX_NODES)) ? int'(MAX_NODES) : num;
      num_nodes = NUM_W'(num); out_sel = SEL_W'(sel); out_inv = inv; start = 1'b1;
      tick();
      start = 1'b0; cfg_we = 1'b0;
      check({tag, "_busy"}, TT_W'(busy), TT_W'(1));
      lat = 0;
      while (!tt_valid && lat < 40) begin
         if (disturb && lat == 0) begin
            start = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_data = DW'($urandom);
            out_sel = SEL_W'($urandom); out_inv = ~inv; num_nodes = NUM_W'($urandom);
         end
         tick();
         start = 1'b0; cfg_we = 1'b0;
         lat++;
      end
      check({tag, "_lat"}, TT_W'(lat), TT_W'(n + 1));
      check({tag, "_data"}, tt_data, ew);
      if (has_c) check({tag, "_const"}, tt_data, exp_c);
      check({tag, "_err"}, TT_W'(err), TT_W'(ee));
      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, "_hold_valid"}, TT_W'(tt_valid), TT_W'(1));
         check({tag, "_hold_data"}, tt_data, ew);
      end
      tt_ready = 1'b1;
      tick();
      tt_ready = 1'b0;
      check({tag, "_done"}, TT_W'({tt_valid, busy}), TT_W'(0));
   endtask

   initial begin
      logic [TT_W-1:0] x0w;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_nodes = '0;
      out_sel = '0; out_inv = 1'b0; start = 1'b0; tt_ready = 1'b0;
      model_clear();
      tick(); tick();
      check("rst_busy", TT_W'(busy), TT_W'(0));
      check("rst_valid", TT_W'(tt_valid), TT_W'(0));
      check("rst_data", tt_data, '0);
      check("rst_err", TT_W'(err), TT_W'(0));
      rst_n = 1'b1;
      tick();

      wr(0, desc(0, 1, 0, 2, 0, 3));
      run("maj", 1, 8, 0, 0, 0, 0, 0, '0, 1, {16{8'hE8}});
      run("maj_inv", 1, 8, 1, 0, 0, 0, 0, '0, 1, {16{8'h17}});
      wr(0, desc(0, 1, 0, 2, 0, 0));
      run("and", 1, 8, 0, 0, 0, 0, 0, '0, 1, {16{8'h88}});
      wr(0, desc(0, 1, 0, 2, 1, 0));
      run("or", 1, 8, 0, 0, 0, 0, 0, '0, 1, {16{8'hEE}});
      x0w = {64{2'b10}};
      run("x0", 0, 1, 0, 0, 0, 0, 0, '0, 1, x0w);
      run("ones", 0, 0, 1, 0, 0, 0, 0, '0, 1, {TT_W{1'b1}});

      wr(0, desc(0, 1, 0, 2, 0, 3));
      wr(1, desc(0, 8, 0, 4, 0, 0));
      run("chain", 2, 9, 0, 5, 0, 0, 0, '0, 1, {8{16'hE800}});
      run("same_wr", 2, 9, 0, 0, 0, 1, 1, desc(0, 8, 0, 4, 1, 0), 1, {8{16'hFFE8}});
      run("disturb", 2, 9, 0, 1, 1, 0, 0, '0, 1, {8{16'hFFE8}});
      run("sat", 20, 12, 0, 0, 0, 0, 0, '0, 0, '0);
      run("oor", 1, 30, 0, 0, 0, 0, 0, '0, 1, '0);

      wr(0, desc(0, 9, 0, 2, 0, 3));
      run("fwd", 1, 8, 0, 0, 0, 0, 0, '0, 0, '0);
      wr(0, desc(0, 1, 0, 2, 0, 3));
      run("clean", 1, 8, 0, 0, 0, 0, 0, '0, 1, {16{8'hE8}});
      run("fwd_out", 1, 9, 0, 0, 0, 0, 0, '0, 0, '0);

      for (int it = 0; it < 25; it++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int w = 0; w < nw; w++)
            wr(int'($urandom_range(0, MAX_NODES - 1)),
               desc(1'($urandom), int'($urandom_range(0, 31)), 1'($urandom),
                    int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 31))));
         run("rnd", int'($urandom_range(0, 18)), int'($urandom_range(0, 31)), 1'($urandom),
             int'($urandom_range(0, 2)), 0, 0, 0, '0, 0, '0);
      end

      num_nodes = NUM_W'(10); out_sel = SEL_W'(12); out_inv = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", TT_W'(busy), TT_W'(0));
      check("midrst_valid", TT_W'(tt_valid), TT_W'(0));
      check("midrst_data", tt_data, '0);
      model_clear();
      tick();
      rst_n = 1'b1;
      tick();
      run("post_rst", 1, 8, 0, 0, 0, 0, 0, '0, 1, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
